edge_event_arbiter: RTL
=======================

Name: edge_event_arbiter

Overview:
- Multi-channel edge-event controller: per-channel edge detection with a configurable edge mode, one-deep event holding per channel, and round-robin arbitration of pending events onto a single valid/ready event port.
- Sits between synchronised status/interrupt lines and one shared event consumer (e.g. interrupt controller or event FIFO).
- Counts events lost to back-pressure.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- sig_in  input  NUM_CH  level inputs, already synchronous to clk.
- en  input  1  global detection enable.
- mode  input  2*NUM_CH  per-channel mode; bits [2i+1:2i] for channel i: 00 disabled, 01 rising, 10 falling, 11 both.
- evt_valid  output  1  event presented.
- evt_ready  input  1  consumer accepts the event.
- evt_ch  output  $clog2(NUM_CH)  channel index of the presented event.
- evt_edge  output  1  1 = rising, 0 = falling.
- pending  output  NUM_CH  per-channel pending flags.
- drop_cnt  output  CNT_W  saturating count of dropped edges.
- clr_drop  input  1  synchronous clear of drop_cnt.

Behaviour:
- Reset values: evt_valid 0, evt_ch 0, evt_edge 0, pending 0, drop_cnt 0, per-channel prev register 0, round-robin pointer NUM_CH-1 (channel 0 has first priority).
- Detection, per channel, combinational:
  - rise = ~prev & sig; fall = prev & ~sig.
  - det = en & ((mode[0] & rise) | (mode[1] & fall)).
- prev <= sig_in every cycle, regardless of en/mode. Re-enabling therefore never produces a spurious edge.
- prev resets to 0, so an input held high through reset release raises a rising event when its mode includes rising.
- Pending slot, per channel: one flag plus a stored edge type.
  - det with slot empty: slot loads at that posedge.
  - det with slot full and the slot granted at the same posedge: slot reloads with the new edge; no drop.
  - det with slot full and not granted: edge dropped; slot keeps the older edge; drop_cnt increments.
- drop_cnt:
  - Multiple channels dropping in one cycle add their total count.
  - Saturates at 2^CNT_W-1.
  - clr_drop wins over same-cycle drops; result is 0.
- Output FSM:
  - IDLE (evt_valid=0): if any pending, select the first set flag searching from pointer+1 upward with wrap. At the posedge, load evt_ch/evt_edge, clear that flag, pointer <= selected, go to PRESENT.
  - PRESENT (evt_valid=1): evt_ch/evt_edge held stable until evt_valid & evt_ready.
  - On handshake with pending nonempty: load the next winner at the same posedge and stay in PRESENT (back-to-back, one event per cycle).
  - On handshake with pending empty: go to IDLE.
- evt_valid never deasserts without a handshake, except on reset.
- Latency: edge first visible at posedge t (sig_in differs from prev) -> pending set after t -> evt_valid high after posedge t+1 if the port is free.
- Mode or en changes: affect detection only. Existing pending events are still delivered.
- Reset mid-operation: all state clears asynchronously; evt_valid drops immediately; in-flight and pending events are discarded.

Test Plan:
- Reset; mode=01 on ch0, en=1, evt_ready=1; sig_in[0] 0->1 sampled at posedge 10 -> pending[0]=1 after posedge 10; evt_valid=1, evt_ch=0, evt_edge=1 after posedge 11; evt_valid=0 after posedge 12.
- ch1 mode=10: rising on sig_in[1] -> no event; falling -> one event, evt_ch=1, evt_edge=0. Repeat with en=0 -> no event, pending stays 0.
- All 4 channels mode=01, simultaneous rise, evt_ready=1 -> grants ch0,1,2,3 on consecutive cycles with no bubble. Then ch1 and ch3 rise together -> order ch1 then ch3.
- evt_ready=0, ch2 mode=11, sig_in[2] toggles 3 times 3 cycles apart:
  - first event presented, evt_ch/evt_edge stable throughout.
  - second held in pending[2]; third dropped, drop_cnt=1.
  - evt_ready=1 -> the two events arrive in order (edge 1, then 0).
- CNT_W=2: force 5 drops -> drop_cnt saturates at 3. clr_drop pulsed in the same cycle as a drop -> drop_cnt=0.
- Assert rstn low while evt_valid=1 and pending=4'b1010 -> evt_valid, pending and drop_cnt go to 0 without a clock edge. Release with sig_in[0]=1, mode=01 -> one rising event on ch0.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
//   Multi-channel edge-event controller. Each channel detects rising and/or falling
//   edges on a synchronous level input and holds one pending event. Pending events are
//   arbitrated round-robin onto a single valid/ready event port. An edge that arrives
//   while its channel slot is still occupied (and not being granted) is dropped and
//   counted in a saturating counter.
//
// Ports:
//   clk          clock
//   rstn         asynchronous active-low reset
//   sig_in_i     per-channel level inputs, already synchronous to clk
//   en_i         global detection enable
//   mode_i       per-channel edge mode, [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   evt_valid_o  event presented
//   evt_ready_i  consumer accepts the presented event
//   evt_ch_o     channel index of the presented event
//   evt_edge_o   edge type of the presented event (1 rising, 0 falling)
//   pending_o    per-channel pending flags
//   drop_cnt_o   saturating count of dropped edges
//   clr_drop_i   synchronous clear of drop_cnt_o (wins over same-cycle drops)

module edge_event_arbiter #(
   parameter int unsigned NUM_CH = 4,
   // Counter width is kept below 32 so the sum fits the 32-bit arithmetic below.
   parameter int unsigned CNT_W  = 8
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [NUM_CH-1:0]         sig_in_i,
   input  logic                      en_i,
   input  logic [2*NUM_CH-1:0]       mode_i,
   output logic                      evt_valid_o,
   input  logic                      evt_ready_i,
   output logic [$clog2(NUM_CH)-1:0] evt_ch_o,
   output logic                      evt_edge_o,
   output logic [NUM_CH-1:0]         pending_o,
   output logic [CNT_W-1:0]          drop_cnt_o,
   input  logic                      clr_drop_i
);

   localparam int unsigned CH_W = $clog2(NUM_CH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [0:0] {StIdle, StPresent} state_e;

   state_e              state_q, state_d;
   logic [NUM_CH-1:0]   prev_q;
   logic [NUM_CH-1:0]   pend_q, pend_d;
   logic [NUM_CH-1:0]   pend_edge_q, pend_edge_d;
   logic [CH_W-1:0]     ptr_q, ptr_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic                edge_q, edge_d;
   logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

   logic [NUM_CH-1:0]   rise, fall, det;
   logic [NUM_CH-1:0]   gnt;
   logic [NUM_CH-1:0]   drop;
   logic [CH_W-1:0]     sel;
   logic                any_pend;
   logic                load;

   // ------------------------------------------------------------------
   // Edge detection
   // ------------------------------------------------------------------
   always_comb begin
      rise = '0;
      fall = '0;
      det  = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         rise[i] = ~prev_q[i] & sig_in_i[i];
         fall[i] = prev_q[i] & ~sig_in_i[i];
         det[i]  = en_i & ((mode_i[2*i] & rise[i]) | (mode_i[2*i+1] & fall[i]));
      end
   end

   // ------------------------------------------------------------------
   // Round-robin selection: first pending flag above the pointer, with wrap
   // ------------------------------------------------------------------
   assign any_pend = |pend_q;

   always_comb begin : rr_select
      int unsigned idx;
      logic        found;
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         idx = (32'(ptr_q) + k) % NUM_CH;
         if (!found && pend_q[idx]) begin
            found = 1'b1;
            sel   = CH_W'(idx);
         end
      end
   end

   // A new winner is taken whenever the port is free or is being freed this cycle.
   assign load = any_pend & ((state_q == StIdle) | evt_ready_i);

   always_comb begin
      gnt = '0;
      if (load) begin
         gnt[sel] = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Pending slots
   // ------------------------------------------------------------------
   always_comb begin
      pend_d      = pend_q;
      pend_edge_d = pend_edge_q;
      drop        = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (det[i]) begin
            // A slot being granted this cycle frees up in time to take the new edge.
            if (!pend_q[i] || gnt[i]) begin
               pend_d[i]      = 1'b1;
               pend_edge_d[i] = rise[i];
            end else begin
               drop[i] = 1'b1;
            end
         end else if (gnt[i]) begin
            pend_d[i] = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Saturating drop counter
   // ------------------------------------------------------------------
   always_comb begin
      int unsigned ndrop;
      int unsigned sum;
      ndrop = 0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ndrop = ndrop + 32'(drop[i]);
      end
      sum = 32'(drop_cnt_q) + ndrop;
      if (clr_drop_i) begin
         drop_cnt_d = '0;
      end else if (sum > 32'(CNT_MAX)) begin
         drop_cnt_d = CNT_MAX;
      end else begin
         drop_cnt_d = CNT_W'(sum);
      end
   end

   // ------------------------------------------------------------------
   // Output FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      edge_d  = edge_q;
      ptr_d   = ptr_q;
      case (state_q)
         StIdle: begin
            if (load) begin
               state_d = StPresent;
            end
         end
         StPresent: begin
            if (evt_ready_i && !any_pend) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (load) begin
         ch_d   = sel;
         edge_d = pend_edge_q[sel];
         ptr_d  = sel;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StIdle;
         prev_q      <= '0;
         pend_q      <= '0;
         pend_edge_q <= '0;
         ptr_q       <= CH_W'(NUM_CH - 1);
         ch_q        <= '0;
         edge_q      <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= sig_in_i;
         pend_q      <= pend_d;
         pend_edge_q <= pend_edge_d;
         ptr_q       <= ptr_d;
         ch_q        <= ch_d;
         edge_q      <= edge_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign evt_valid_o = (state_q == StPresent);
   assign evt_ch_o    = ch_q;
   assign evt_edge_o  = edge_q;
   assign pending_o   = pend_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule
